// File: rtl/inst_enc_if.sv
// Request/word stream bundle for inst_enc: field-level requests in, 32-bit words out.
interface inst_enc_if;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  in_op;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [63:0] in_imm;
  logic        in_li;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic        out_last;
  logic        out_err;

  modport master (
    output in_valid, in_op, in_funct3, in_funct7, in_rd, in_rs1, in_rs2, in_imm, in_li,
    output out_ready,
    input  in_ready, out_valid, out_inst, out_last, out_err
  );

  modport slave (
    input  in_valid, in_op, in_funct3, in_funct7, in_rd, in_rs1, in_rs2, in_imm, in_li,
    input  out_ready,
    output in_ready, out_valid, out_inst, out_last, out_err
  );
endinterface

// File: rtl/inst_enc.sv
// RV64 instruction encoder: packs field-level requests into 32-bit words on a valid/ready stream.
// Define INST_ENC_LI_EN to expand `li` into a LUI/ADDIW pair; otherwise `li` is ADDI-only.
module inst_enc (
  input  logic        clk,
  input  logic        rst_n,
  inst_enc_if.slave   bus
);

  localparam logic [6:0] OP_LOAD     = 7'h03;
  localparam logic [6:0] OP_MISC     = 7'h0F;
  localparam logic [6:0] OP_IMM      = 7'h13;
  localparam logic [6:0] OP_AUIPC    = 7'h17;
  localparam logic [6:0] OP_IMM_W    = 7'h1B;
  localparam logic [6:0] OP_STORE    = 7'h23;
  localparam logic [6:0] OP_AMO      = 7'h2F;
  localparam logic [6:0] OP_REG      = 7'h33;
  localparam logic [6:0] OP_LUI      = 7'h37;
  localparam logic [6:0] OP_REG_W    = 7'h3B;
  localparam logic [6:0] OP_BRANCH   = 7'h63;
  localparam logic [6:0] OP_JALR     = 7'h67;
  localparam logic [6:0] OP_JAL      = 7'h6F;
  localparam logic [6:0] OP_SYSTEM   = 7'h73;

`ifdef INST_ENC_LI_EN
  typedef enum logic [1:0] {IDLE = 2'd0, ONE = 2'd1, FIRST = 2'd2} state_e;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, ONE = 2'd1} state_e;
`endif

  typedef struct packed {
    logic        err;
    logic [31:0] inst;
  } enc_t;

  // True when v is sign-representable in n bits (bits [63:n-1] all equal).
  function automatic logic fits(input logic [63:0] v, input int n);
    logic [63:0] s;
    s = $signed(v) >>> (n - 1);
    return (s == '0) || (s == '1);
  endfunction

  function automatic enc_t encode(
    input logic [6:0]  op,
    input logic [2:0]  f3,
    input logic [6:0]  f7,
    input logic [4:0]  rd,
    input logic [4:0]  rs1,
    input logic [4:0]  rs2,
    input logic [63:0] imm
  );
    enc_t r;
    r.err  = 1'b0;
    r.inst = '0;
    case (op)
      OP_REG, OP_REG_W, OP_AMO: r.inst = {f7, rs2, rs1, f3, rd, op};
      OP_LOAD, OP_IMM, OP_IMM_W, OP_JALR, OP_MISC, OP_SYSTEM: begin
        r.err = !fits(imm, 12);
        // SLLI/SRLI/SRAI carry a 6-bit shamt, the W forms a 5-bit one.
        if (op == OP_IMM && f3[1:0] == 2'b01)
          r.inst = {f7[6:1], imm[5:0], rs1, f3, rd, op};
        else if (op == OP_IMM_W && f3[1:0] == 2'b01)
          r.inst = {f7, imm[4:0], rs1, f3, rd, op};
        else
          r.inst = {imm[11:0], rs1, f3, rd, op};
      end
      OP_STORE: begin
        r.err  = !fits(imm, 12);
        r.inst = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
      end
      OP_BRANCH: begin
        r.err  = !fits(imm, 13) || imm[0];
        r.inst = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
      end
      OP_LUI, OP_AUIPC: begin
        r.err  = !fits(imm, 32) || (imm[11:0] != 12'd0);
        r.inst = {imm[31:12], rd, op};
      end
      OP_JAL: begin
        r.err  = !fits(imm, 21) || imm[0];
        r.inst = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
      end
      default: r.err = 1'b1;
    endcase
    if (r.err) r.inst = '0;
    return r;
  endfunction

  state_e      state_q, state_d;
  logic [31:0] inst_q, inst_d;
  logic        last_q, last_d;
  logic        err_q, err_d;
  logic        accept;
  enc_t        enc;
  logic        li_fits12;
  logic [31:0] li_addi;
`ifdef INST_ENC_LI_EN
  logic [31:0] pend_q, pend_d;
  logic        li_fits32;
  logic [31:0] li_sum;
  logic [31:0] li_lui;
  logic [31:0] li_addiw;
`endif

  assign bus.in_ready  = (state_q == IDLE) || ((state_q == ONE) && bus.out_ready);
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.out_valid = (state_q != IDLE);
  assign bus.out_inst  = inst_q;
  assign bus.out_last  = last_q;
  assign bus.out_err   = err_q;

  assign enc = encode(bus.in_op, bus.in_funct3, bus.in_funct7, bus.in_rd,
                      bus.in_rs1, bus.in_rs2, bus.in_imm);

  assign li_fits12 = fits(bus.in_imm, 12);
  assign li_addi   = {bus.in_imm[11:0], 5'd0, 3'b000, bus.in_rd, OP_IMM};
`ifdef INST_ENC_LI_EN
  // Adding 0x800 rounds hi up whenever the sign-extended lo will be negative.
  assign li_fits32 = fits(bus.in_imm, 32);
  assign li_sum    = bus.in_imm[31:0] + 32'h0000_0800;
  assign li_lui    = {li_sum[31:12], bus.in_rd, OP_LUI};
  assign li_addiw  = {bus.in_imm[11:0], bus.in_rd, 3'b000, bus.in_rd, OP_IMM_W};
`endif

  always_comb begin
    state_d = state_q;
    inst_d  = inst_q;
    last_d  = last_q;
    err_d   = err_q;
`ifdef INST_ENC_LI_EN
    pend_d  = pend_q;
`endif
    case (state_q)
      IDLE: state_d = IDLE;
      ONE:  if (bus.out_ready) state_d = IDLE;
`ifdef INST_ENC_LI_EN
      FIRST: if (bus.out_ready) begin
        state_d = ONE;
        inst_d  = pend_q;
        last_d  = 1'b1;
        err_d   = 1'b0;
      end
`endif
      default: state_d = IDLE;
    endcase

    if (accept) begin
      state_d = ONE;
      last_d  = 1'b1;
      err_d   = 1'b0;
      if (bus.in_li) begin
        if (li_fits12) begin
          inst_d = li_addi;
`ifdef INST_ENC_LI_EN
        end else if (li_fits32 && bus.in_imm[11:0] == 12'd0) begin
          inst_d = li_lui;
        end else if (li_fits32) begin
          state_d = FIRST;
          inst_d  = li_lui;
          last_d  = 1'b0;
          pend_d  = li_addiw;
`endif
        end else begin
          inst_d = '0;
          err_d  = 1'b1;
        end
      end else begin
        inst_d = enc.inst;
        err_d  = enc.err;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      inst_q  <= '0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef INST_ENC_LI_EN
      pend_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      inst_q  <= inst_d;
      last_q  <= last_d;
      err_q   <= err_d;
`ifdef INST_ENC_LI_EN
      pend_q  <= pend_d;
`endif
    end
  end

endmodule

// File: doc/inst_enc.md
# inst_enc

RV64 instruction encoder. Takes field-level instruction requests (opcode, funct3/funct7, register indices, 64-bit immediate) and packs them into 32-bit RISC-V instruction words. The field layout and opcode set exactly mirror the dec32 decoder, so an encoded word decodes back to the same fields. It can also expand a `li rd, imm` pseudo-instruction into a LUI/ADDIW pair. It feeds instruction words to the debug program buffer and to the self-test instruction injector through a valid/ready stream.

## Interface
Parameters: none.
- `clk`  in  1  clock, all state on rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `in_valid`  in  1  request valid
- `in_ready`  out  1  request accepted when `in_valid & in_ready`
- `in_op`  in  7  major opcode (LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, OP_IMM, OP_IMM_W, OP_REG, OP_REG_W, SYSTEM, MISC, AMO)
- `in_funct3`  in  3  funct3
- `in_funct7`  in  7  funct7; for AMO, bits [1:0] are aq/rl
- `in_rd`, `in_rs1`, `in_rs2`  in  5 each  register indices; for SYSTEM, `in_rs1` carries the CSR uimm
- `in_imm`  in  64  immediate, byte offset for B/J formats
- `in_li`  in  1  pseudo `li in_rd, in_imm`; `in_op`/funct fields ignored
- `out_valid`  out  1  word valid
- `out_ready`  in  1  word consumed when `out_valid & out_ready`
- `out_inst`  out  32  encoded word
- `out_last`  out  1  last word of the current request
- `out_err`  out  1  request unencodable; `out_inst` = 0

## Operation
- Format is selected by `in_op`:
  - R: OP_REG, OP_REG_W, AMO
  - I: LOAD, OP_IMM, OP_IMM_W, JALR, MISC
  - S: STORE
  - B: BRANCH
  - U: LUI, AUIPC
  - J: JAL
  - SYSTEM: {imm[11:0], rs1, funct3, rd, op}
- Placement per base ISA:
  - S: imm[11:5]→[31:25], imm[4:0]→[11:7]
  - B: imm[12]→[31], imm[10:5]→[30:25], imm[4:1]→[11:8], imm[11]→[7]
  - U: imm[31:12]→[31:12]
  - J: imm[20]→[31], imm[10:1]→[30:21], imm[11]→[20], imm[19:12]→[19:12]
- Shifts:
  - OP_IMM with funct3 001/101: [31:26] = funct7[6:1], [25:20] = imm[5:0].
  - OP_IMM_W with funct3 001/101: [31:25] = funct7, [24:20] = imm[4:0].
- Error (`out_err`=1) on any of:
  - unknown opcode
  - I/S/SYSTEM imm not sign-representable in 12 bits
  - B imm outside 13 bits or imm[0]=1
  - J imm outside 21 bits or imm[0]=1
  - U imm outside 32 bits or imm[11:0]≠0
- LI expansion (when compiled in):
  - fits12 (imm[63:11] all equal): single `ADDI rd,x0,imm[11:0]`.
  - Else fits32 (imm[63:31] all equal): hi = (imm[31:0]+32'h800)[31:12], lo = imm[11:0], arithmetic mod 2^32.
    - lo=0: single `LUI rd,hi`.
    - Otherwise two words: `LUI rd,hi`, then `ADDIW rd,rd,lo`.
  - Else: error.
- FSM states:
  - IDLE: output empty.
  - ONE: holding a single or final word.
  - FIRST: holding the LUI of a pair; ADDIW pending in an internal register.
- Transitions:
  - IDLE + accept → ONE, or FIRST for a pair.
  - ONE + out handshake → IDLE, or directly to ONE/FIRST if a new request is accepted in the same cycle.
  - FIRST + out handshake → ONE, loading the ADDIW word.
- Handshake:
  - `in_ready` = IDLE | (ONE & `out_ready`); never asserted in FIRST.
  - `out_last` = 1 in ONE, 0 in FIRST.
  - Output fields hold stable while `out_valid & ~out_ready`.
- Error requests are emitted as one word with `out_last`=1.

## Timing
- Reset: state IDLE; `out_valid`, `out_inst`, `out_last`, `out_err` = 0; pending-word register = 0.
- `in_ready` resets to 1 and is combinational from state and `out_ready`.
- Latency: request accepted at edge N → word visible after edge N, with `out_valid`=1 in cycle N+1.
- Throughput: one word per cycle with `out_ready` held high.
  - Single-word requests sustain one request per cycle.
  - A pair occupies two output cycles and blocks input for one cycle.
- Reset asserted mid-pair: the pending ADDIW is discarded and state returns to IDLE immediately, asynchronously.

## Configuration
- `INST_ENC_LI_EN` defined: LI expansion as above.
- Undefined:
  - FIRST state and the pending register are removed.
  - `in_li` encodes `ADDI rd,x0,imm[11:0]` when fits12; otherwise `out_err`=1.
  - `out_last` is always 1.

## Test plan
- ADD: op=OP_REG, f3=0, f7=0, rd=1, rs1=2, rs2=3 → 32'h003100B3, last=1, err=0.
- BEQ: op=BRANCH, f3=0, rs1=1, rs2=2, imm=-4 → 32'hFE208EE3. Same with imm=3 → err=1, inst=0.
- LI pair and carry case (LI_EN):
  - li x5, 0x12345678 → 32'h123452B7 (last=0), then 32'h6782829B (last=1). `in_ready`=0 during FIRST.
  - li x5, 0x7FFFF800 → hi=0x80000, lo=0x800: 32'h800002B7, then 32'h8002829B.
- LI single words: li x1, -1 → 32'hFFF00093. li x1, 0x1000 → 32'h000010B7. Both single word, last=1.
- Back-pressure: hold `out_ready`=0 for 3 cycles mid-pair → LUI word stable and no new accept; then stream 4 back-to-back ADDIs at one per cycle.
- Reset: assert `rst_n`=0 while in FIRST → `out_valid`=0 asynchronously; after release, the next request encodes correctly with no stale ADDIW emitted.
